// File: rtl/gm_event_pkg.sv
// Shared event-ingress types: default widths, the canonical event entry layout
// and a saturating counter helper.
package gm_event_pkg;

    localparam int GM_DEF_NUM_CH      = 2;
    localparam int GM_DEF_COORD_BITS  = 4;
    localparam int GM_DEF_TS_BITS     = 16;
    localparam int GM_DEF_TS_PRESCALE = 1;
    localparam int GM_DEF_FIFO_DEPTH  = 4;
    localparam int GM_DEF_ACT_STRETCH = 1048575;
    localparam int GM_DROP_CNT_BITS   = 16;

    // Field order {x, y, pol, ts}; the arbiter rebuilds this layout at its own widths.
    typedef struct packed {
        logic [GM_DEF_COORD_BITS-1:0] x;
        logic [GM_DEF_COORD_BITS-1:0] y;
        logic                         pol;
        logic [GM_DEF_TS_BITS-1:0]    ts;
    } gm_event_t;

    function automatic logic [GM_DROP_CNT_BITS-1:0] sat_inc16(input logic [GM_DROP_CNT_BITS-1:0] v);
        return (v == {GM_DROP_CNT_BITS{1'b1}}) ? v : v + GM_DROP_CNT_BITS'(1);
    endfunction

endpackage

// File: rtl/event_ch_fifo.sv
// Single-channel synchronous FIFO with full/empty flags; pointers carry an
// extra wrap bit so full and empty are distinguishable at equal addresses.
module event_ch_fifo
    import gm_event_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = GM_DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/event_ingress_arbiter.sv
// Multi-channel event ingress: timestamps events, buffers them per channel and
// merges them round-robin into one registered stream. Optional drop mode via
// INGRESS_DROP_MODE_EN (adds drop_count port).
module event_ingress_arbiter
    import gm_event_pkg::*;
#(
    parameter int NUM_CH      = GM_DEF_NUM_CH,
    parameter int COORD_BITS  = GM_DEF_COORD_BITS,
    parameter int TS_BITS     = GM_DEF_TS_BITS,
    parameter int TS_PRESCALE = GM_DEF_TS_PRESCALE,
    parameter int FIFO_DEPTH  = GM_DEF_FIFO_DEPTH,
    parameter int ACT_STRETCH = GM_DEF_ACT_STRETCH,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*COORD_BITS-1:0] in_x,
    input  logic [NUM_CH*COORD_BITS-1:0] in_y,
    input  logic [NUM_CH-1:0]            in_pol,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [COORD_BITS-1:0]        out_x,
    output logic [COORD_BITS-1:0]        out_y,
    output logic                         out_pol,
    output logic [TS_BITS-1:0]           out_ts,
    output logic [CH_W-1:0]              out_ch,
    input  logic                         out_ready,
    output logic [TS_BITS-1:0]           timestamp,
    output logic [NUM_CH-1:0]            activity
`ifdef INGRESS_DROP_MODE_EN
    ,
    output logic [NUM_CH*GM_DROP_CNT_BITS-1:0] drop_count
`endif
);

    localparam int PS_W  = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
    localparam int ACT_W = (ACT_STRETCH > 0) ? $clog2(ACT_STRETCH + 1) : 1;

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
        logic                  pol;
        logic [TS_BITS-1:0]    ts;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [PS_W-1:0]        ps_cnt;
    logic                   ps_tc;
    entry_t [NUM_CH-1:0]    fifo_din, fifo_dout;
    logic   [NUM_CH-1:0]    fifo_full, fifo_empty, fifo_push, fifo_pop, accept;
    logic   [CH_W-1:0]      rr_ptr, gnt;
    logic                   gnt_valid, load;
    entry_t                 out_q;

    // ---------------- timestamp ----------------
    assign ps_tc = (ps_cnt == PS_W'(TS_PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt    <= '0;
            timestamp <= '0;
        end else begin
            ps_cnt <= ps_tc ? '0 : ps_cnt + PS_W'(1);
            if (ps_tc) timestamp <= timestamp + TS_BITS'(1);
        end
    end

    // ---------------- per-channel ingress ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACT_W-1:0] act_cnt;

`ifdef INGRESS_DROP_MODE_EN
        logic [GM_DROP_CNT_BITS-1:0] drop_cnt;

        assign in_ready[c] = rst_n;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                         drop_cnt <= '0;
            else if (accept[c] && fifo_full[c]) drop_cnt <= sat_inc16(drop_cnt);
        end

        assign drop_count[c*GM_DROP_CNT_BITS +: GM_DROP_CNT_BITS] = drop_cnt;
`else
        assign in_ready[c] = rst_n && !fifo_full[c];
`endif

        assign accept[c]    = in_valid[c] && in_ready[c];
        assign fifo_push[c] = accept[c] && !fifo_full[c];
        assign fifo_pop[c]  = load && (gnt == CH_W'(c));
        assign fifo_din[c]  = {in_x[c*COORD_BITS +: COORD_BITS],
                               in_y[c*COORD_BITS +: COORD_BITS],
                               in_pol[c], timestamp};

        // A dropped event still counts as activity on its channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              act_cnt <= '0;
            else if (accept[c])      act_cnt <= ACT_W'(ACT_STRETCH);
            else if (act_cnt != '0)  act_cnt <= act_cnt - ACT_W'(1);
        end

        assign activity[c] = (act_cnt != '0);

        event_ch_fifo #(
            .W     (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (fifo_push[c]),
            .push_data (fifo_din[c]),
            .pop       (fifo_pop[c]),
            .pop_data  (fifo_dout[c]),
            .full      (fifo_full[c]),
            .empty     (fifo_empty[c])
        );
    end

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!gnt_valid && !fifo_empty[idx]) begin
                gnt_valid = 1'b1;
                gnt       = CH_W'(idx);
            end
        end
    end

    assign load = (!out_valid || out_ready) && gnt_valid;

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_q     <= fifo_dout[gnt];
            out_ch    <= gnt;
            out_valid <= 1'b1;
            rr_ptr    <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_x   = out_q.x;
    assign out_y   = out_q.y;
    assign out_pol = out_q.pol;
    assign out_ts  = out_q.ts;

endmodule
